// File: rtl/alu_serial_sequencer_if.sv
// Bus bundle joining the control unit, alu_serial_sequencer and one ALU_1bit slice.
// master = control unit, slave = sequencer, slice = the ALU_1bit slice.
interface alu_serial_sequencer_if #(
    parameter int unsigned WIDTH = 24
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    logic             slice_a;
    logic             slice_b;
    logic             slice_a_invert;
    logic             slice_b_invert;
    logic             slice_carry_in;
    logic             slice_less;
    logic [2:0]       slice_operation;
    logic             slice_result;
    logic             slice_carry_out;

    modport master (
        output start, alu_op, a, b,
        input  ready, done, result, zero, overflow
    );

    modport slave (
        input  start, alu_op, a, b,
        input  slice_result, slice_carry_out,
        output ready, done, result, zero, overflow,
        output slice_a, slice_b, slice_a_invert, slice_b_invert,
        output slice_carry_in, slice_less, slice_operation
    );

    modport slice (
        input  slice_a, slice_b, slice_a_invert, slice_b_invert,
        input  slice_carry_in, slice_less, slice_operation,
        output slice_result, slice_carry_out
    );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU driver: steps one ALU_1bit slice through bits 0..WIDTH-1, one bit per clock.
// Optional macro ALU_SEQ_SLTU_EN adds ALUOp 1111 (SLTU, unsigned set-less-than).
module alu_serial_sequencer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 5
) (
    input logic                  Clock,
    input logic                  Reset,
    alu_serial_sequencer_if.slave bus
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_SEQ_SLTU_EN
    localparam logic [3:0] OP_SLTU = 4'b1111;
`endif

    localparam logic [2:0] SOP_AND  = 3'b000;
    localparam logic [2:0] SOP_OR   = 3'b001;
    localparam logic [2:0] SOP_ADD  = 3'b010;
    localparam logic [2:0] SOP_LESS = 3'b011;
    localparam logic [2:0] SOP_XOR  = 3'b100;

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        LESSPASS = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state, state_nx;

    logic [WIDTH-1:0] a_q, a_nx;
    logic [WIDTH-1:0] b_q, b_nx;
    logic [2:0]       sop_q, sop_nx;
    logic             ainv_q, ainv_nx;
    logic             binv_q, binv_nx;
    logic             less_q, less_nx;
    logic             sltu_q, sltu_nx;
    logic             arith_q, arith_nx;
    logic [CNT_W-1:0] idx_q, idx_nx;
    logic             carry_q, carry_nx;
    logic             set_q, set_nx;
    logic [WIDTH-1:0] result_q, result_nx;
    logic             zero_q, zero_nx;
    logic             ovf_q, ovf_nx;
    logic             ready_q, ready_nx;
    logic             done_q, done_nx;
    logic             run_ovf;

    logic             slice_a_q, slice_a_nx;
    logic             slice_b_q, slice_b_nx;
    logic             slice_ainv_q, slice_ainv_nx;
    logic             slice_binv_q, slice_binv_nx;
    logic             slice_cin_q, slice_cin_nx;
    logic             slice_less_q, slice_less_nx;
    logic [2:0]       slice_op_q, slice_op_nx;

    logic             dec_valid;
    logic [2:0]       dec_sop;
    logic             dec_ainv;
    logic             dec_binv;
    logic             dec_cin;
    logic             dec_less;
    logic             dec_sltu;
    logic             dec_arith;

    // Opcode decode, latched alongside the operands on accept
    always_comb begin
        dec_valid = 1'b0;
        dec_sop   = SOP_AND;
        dec_ainv  = 1'b0;
        dec_binv  = 1'b0;
        dec_cin   = 1'b0;
        dec_less  = 1'b0;
        dec_sltu  = 1'b0;
        dec_arith = 1'b0;
        case (bus.alu_op)
            OP_AND: dec_valid = 1'b1;
            OP_OR: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_OR;
            end
            OP_ADD: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_ADD;
                dec_arith = 1'b1;
            end
            OP_XOR: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_XOR;
            end
            OP_SUB: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_ADD;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_arith = 1'b1;
            end
            OP_SLT: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_ADD;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_less  = 1'b1;
            end
            OP_NOR: begin
                dec_valid = 1'b1;
                dec_ainv  = 1'b1;
                dec_binv  = 1'b1;
            end
`ifdef ALU_SEQ_SLTU_EN
            OP_SLTU: begin
                dec_valid = 1'b1;
                dec_sop   = SOP_ADD;
                dec_binv  = 1'b1;
                dec_cin   = 1'b1;
                dec_less  = 1'b1;
                dec_sltu  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sequencer next-state and datapath update
    always_comb begin
        state_nx  = state;
        a_nx      = a_q;
        b_nx      = b_q;
        sop_nx    = sop_q;
        ainv_nx   = ainv_q;
        binv_nx   = binv_q;
        less_nx   = less_q;
        sltu_nx   = sltu_q;
        arith_nx  = arith_q;
        idx_nx    = idx_q;
        carry_nx  = carry_q;
        set_nx    = set_q;
        result_nx = result_q;
        zero_nx   = zero_q;
        ovf_nx    = ovf_q;
        done_nx   = 1'b0;
        run_ovf   = 1'b0;

        case (state)
            IDLE: begin
                if (ready_q && bus.start) begin
                    a_nx      = bus.a;
                    b_nx      = bus.b;
                    sop_nx    = dec_sop;
                    ainv_nx   = dec_ainv;
                    binv_nx   = dec_binv;
                    less_nx   = dec_less;
                    sltu_nx   = dec_sltu;
                    arith_nx  = dec_arith;
                    idx_nx    = '0;
                    carry_nx  = dec_cin;
                    set_nx    = 1'b0;
                    result_nx = '0;
                    ovf_nx    = 1'b0;
                    state_nx  = dec_valid ? RUN : DONE;
                end
            end
            RUN: begin
                result_nx[idx_q] = bus.slice_result;
                carry_nx         = bus.slice_carry_out;
                idx_nx           = idx_q + CNT_W'(1);
                if (idx_q == IDX_LAST) begin
                    // carry_q is the carry into the MSB, slice_carry_out the carry out of it
                    run_ovf  = carry_q ^ bus.slice_carry_out;
                    set_nx   = sltu_q ? ~bus.slice_carry_out : (bus.slice_result ^ run_ovf);
                    ovf_nx   = arith_q & run_ovf;
                    idx_nx   = '0;
                    state_nx = less_q ? LESSPASS : DONE;
                end
            end
            LESSPASS: begin
                result_nx[idx_q] = bus.slice_result;
                idx_nx           = idx_q + CNT_W'(1);
                if (idx_q == IDX_LAST) begin
                    idx_nx   = '0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                zero_nx  = (result_q == '0);
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Ready stays low through the Done cycle so a request there is not taken
        ready_nx = (state_nx == IDLE) && (state != DONE);
    end

    // Slice drive for the bit the next cycle will evaluate
    always_comb begin
        slice_a_nx    = 1'b0;
        slice_b_nx    = 1'b0;
        slice_ainv_nx = 1'b0;
        slice_binv_nx = 1'b0;
        slice_cin_nx  = 1'b0;
        slice_less_nx = 1'b0;
        slice_op_nx   = SOP_AND;
        case (state_nx)
            RUN: begin
                slice_a_nx    = a_nx[idx_nx];
                slice_b_nx    = b_nx[idx_nx];
                slice_ainv_nx = ainv_nx;
                slice_binv_nx = binv_nx;
                slice_cin_nx  = carry_nx;
                slice_op_nx   = sop_nx;
            end
            LESSPASS: begin
                slice_a_nx    = a_nx[idx_nx];
                slice_b_nx    = b_nx[idx_nx];
                slice_less_nx = (idx_nx == '0) ? set_nx : 1'b0;
                slice_op_nx   = SOP_LESS;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sop_q        <= SOP_AND;
            ainv_q       <= 1'b0;
            binv_q       <= 1'b0;
            less_q       <= 1'b0;
            sltu_q       <= 1'b0;
            arith_q      <= 1'b0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            set_q        <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b1;
            ovf_q        <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            slice_a_q    <= 1'b0;
            slice_b_q    <= 1'b0;
            slice_ainv_q <= 1'b0;
            slice_binv_q <= 1'b0;
            slice_cin_q  <= 1'b0;
            slice_less_q <= 1'b0;
            slice_op_q   <= SOP_AND;
        end else begin
            state        <= state_nx;
            a_q          <= a_nx;
            b_q          <= b_nx;
            sop_q        <= sop_nx;
            ainv_q       <= ainv_nx;
            binv_q       <= binv_nx;
            less_q       <= less_nx;
            sltu_q       <= sltu_nx;
            arith_q      <= arith_nx;
            idx_q        <= idx_nx;
            carry_q      <= carry_nx;
            set_q        <= set_nx;
            result_q     <= result_nx;
            zero_q       <= zero_nx;
            ovf_q        <= ovf_nx;
            ready_q      <= ready_nx;
            done_q       <= done_nx;
            slice_a_q    <= slice_a_nx;
            slice_b_q    <= slice_b_nx;
            slice_ainv_q <= slice_ainv_nx;
            slice_binv_q <= slice_binv_nx;
            slice_cin_q  <= slice_cin_nx;
            slice_less_q <= slice_less_nx;
            slice_op_q   <= slice_op_nx;
        end
    end

    assign bus.ready           = ready_q;
    assign bus.done            = done_q;
    assign bus.result          = result_q;
    assign bus.zero            = zero_q;
    assign bus.overflow        = ovf_q;
    assign bus.slice_a         = slice_a_q;
    assign bus.slice_b         = slice_b_q;
    assign bus.slice_a_invert  = slice_ainv_q;
    assign bus.slice_b_invert  = slice_binv_q;
    assign bus.slice_carry_in  = slice_cin_q;
    assign bus.slice_less      = slice_less_q;
    assign bus.slice_operation = slice_op_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: behavioural ALU slice plus a word-level reference model.
module tb_alu_serial_sequencer;

    localparam int unsigned WIDTH   = 24;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TIMEOUT = 200;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    alu_serial_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    // One ALU_1bit slice
    logic eff_a, eff_b, slice_res_c;
    assign eff_a = bus.slice_a ^ bus.slice_a_invert;
    assign eff_b = bus.slice_b ^ bus.slice_b_invert;
    always_comb begin
        case (bus.slice_operation)
            3'b000:  slice_res_c = eff_a & eff_b;
            3'b001:  slice_res_c = eff_a | eff_b;
            3'b010:  slice_res_c = eff_a ^ eff_b ^ bus.slice_carry_in;
            3'b011:  slice_res_c = bus.slice_less;
            3'b100:  slice_res_c = eff_a ^ eff_b;
            default: slice_res_c = 1'b0;
        endcase
    end
    assign bus.slice_result    = slice_res_c;
    assign bus.slice_carry_out = (eff_a & eff_b) | (eff_a & bus.slice_carry_in) | (eff_b & bus.slice_carry_in);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Word-level expectation: result, overflow, edges from accept to Done, first carry-in
    task automatic ref_model(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             output logic [WIDTH-1:0] r, output logic ovf, output int lat, output logic cin);
        r   = '0;
        ovf = 1'b0;
        lat = 1;
        cin = 1'b0;
        case (op)
            4'b0000: begin r = a & b;    lat = int'(WIDTH) + 1; end
            4'b0001: begin r = a | b;    lat = int'(WIDTH) + 1; end
            4'b0011: begin r = a ^ b;    lat = int'(WIDTH) + 1; end
            4'b1100: begin r = ~(a | b); lat = int'(WIDTH) + 1; end
            4'b0010: begin
                r   = a + b;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                lat = int'(WIDTH) + 1;
            end
            4'b0110: begin
                r   = a - b;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                lat = int'(WIDTH) + 1;
                cin = 1'b1;
            end
            4'b0111: begin
                r   = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
                lat = 2 * int'(WIDTH) + 1;
                cin = 1'b1;
            end
`ifdef ALU_SEQ_SLTU_EN
            4'b1111: begin
                r   = (a < b) ? WIDTH'(1) : '0;
                lat = 2 * int'(WIDTH) + 1;
                cin = 1'b1;
            end
`endif
            default: ;
        endcase
    endtask

    function automatic logic [6:0] slice_bits();
        return {bus.slice_a, bus.slice_b, bus.slice_a_invert, bus.slice_b_invert,
                bus.slice_carry_in, bus.slice_less, (bus.slice_operation != 3'b000)};
    endfunction

    // Wait for Ready, present the request, return #1 after the accept edge
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int unsigned waited = 0;
        while (bus.ready !== 1'b1 && waited < TIMEOUT) begin
            @(posedge Clock); #1;
            waited++;
        end
        check_eq("ready_before_start", 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge Clock); #1;
        bus.start  = 1'b0;
    endtask

    // Follow an accepted op to its Done cycle and check everything it produced
    task automatic finish_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit noise, input bit hold_next,
                             input logic [3:0] nop, input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
        logic [WIDTH-1:0] exp_r;
        logic             exp_ovf, exp_cin;
        int               exp_lat;
        int               cnt = 0;
        ref_model(op, a, b, exp_r, exp_ovf, exp_lat, exp_cin);
        check_eq("first_carry_in", 32'(bus.slice_carry_in), 32'(exp_cin));
        check_eq("ready_after_accept", 32'(bus.ready), 32'd0);
        while (bus.done !== 1'b1 && cnt < int'(TIMEOUT)) begin
            if (noise && (cnt == 3 || cnt == 10)) begin
                bus.start  = 1'b1;
                bus.alu_op = 4'b0000;
                bus.a      = WIDTH'($urandom);
                check_eq("ready_busy", 32'(bus.ready), 32'd0);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge Clock); #1;
            cnt++;
        end
        bus.start = 1'b0;
        check_eq("latency", 32'(cnt), 32'(exp_lat));
        check_eq("result", 32'(bus.result), 32'(exp_r));
        check_eq("zero", 32'(bus.zero), 32'(exp_r == '0));
        check_eq("overflow", 32'(bus.overflow), 32'(exp_ovf));
        check_eq("ready_in_done", 32'(bus.ready), 32'd0);
        check_eq("slice_idle_in_done", 32'(slice_bits()), 32'd0);
        if (hold_next) begin
            bus.start  = 1'b1;
            bus.alu_op = nop;
            bus.a      = na;
            bus.b      = nb;
        end
        @(posedge Clock); #1;
        check_eq("done_single_pulse", 32'(bus.done), 32'd0);
        check_eq("ready_after_done", 32'(bus.ready), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        issue(op, a, b);
        finish_op(op, a, b, 1'b0, 1'b0, 4'b0000, '0, '0);
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'(24'h800000);
            3:       return WIDTH'(24'h7FFFFF);
            default: return WIDTH'($urandom);
        endcase
    endfunction

    logic [3:0] op_pool [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                                4'b0111, 4'b1100, 4'b1111, 4'b0101};

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [3:0]       rop;
        bit               saw_done;

        bus.start  = 1'b0;
        bus.alu_op = 4'b0000;
        bus.a      = '0;
        bus.b      = '0;
        Reset      = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        check_eq("reset_ready", 32'(bus.ready), 32'd1);
        check_eq("reset_done", 32'(bus.done), 32'd0);
        check_eq("reset_result", 32'(bus.result), 32'd0);
        check_eq("reset_zero", 32'(bus.zero), 32'd1);
        check_eq("reset_overflow", 32'(bus.overflow), 32'd0);
        check_eq("reset_slice", 32'(slice_bits()), 32'd0);

        issue(4'b0010, 24'h7FFFFF, 24'h000001);
        finish_op(4'b0010, 24'h7FFFFF, 24'h000001, 1'b1, 1'b0, 4'b0000, '0, '0);

        run_op(4'b0110, 24'h000005, 24'h000005);
        run_op(4'b0111, 24'hFFFFFF, 24'h000001);
        run_op(4'b0111, 24'h000001, 24'hFFFFFF);

        // NOR with a request held through its Done cycle, taken the cycle after as XOR
        issue(4'b1100, 24'h0F0F0F, 24'h00FF00);
        finish_op(4'b1100, 24'h0F0F0F, 24'h00FF00, 1'b0, 1'b1, 4'b0011, 24'h0F0F0F, 24'h00FF00);
        issue(4'b0011, 24'h0F0F0F, 24'h00FF00);
        finish_op(4'b0011, 24'h0F0F0F, 24'h00FF00, 1'b0, 1'b0, 4'b0000, '0, '0);

        run_op(4'b0101, 24'h123456, 24'h654321);
        run_op(4'b1111, 24'h000001, 24'h000002);

        // Reset while RUN is on bit 12
        issue(4'b0010, 24'h00F000, 24'h000FFF);
        repeat (12) begin
            @(posedge Clock); #1;
        end
        check_eq("slice_a_bit12", 32'(bus.slice_a), 32'd1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check_eq("abort_ready", 32'(bus.ready), 32'd1);
        check_eq("abort_result", 32'(bus.result), 32'd0);
        check_eq("abort_zero", 32'(bus.zero), 32'd1);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_slice", 32'(slice_bits()), 32'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge Clock); #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);
        run_op(4'b0010, 24'h000001, 24'h000002);

        for (int i = 0; i < 40; i++) begin
            rop = op_pool[$urandom_range(0, 8)];
            ra  = rand_operand();
            rb  = rand_operand();
            run_op(rop, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Bit-serial driver for one ALU_1bit slice. It evaluates a full WIDTH-bit ALU operation by stepping the slice through bits 0..WIDTH-1, one bit per clock. It drives the slice's A, B, AInvert, BInvert, CarryIn, LESS and Operation inputs, and feeds each CarryOut back as the next CarryIn. It sits between the control unit (Start/ALUOp/operands) and the slice, and is the area-minimal execute option for the 24-bit CPU.

Parameters:
WIDTH, 24, operand/result width in bits
CNT_W, 5, bit-index counter width; must satisfy 2^CNT_W >= WIDTH

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
Start  input  1  request; accepted only when Ready=1
ALUOp  input  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1100 NOR
A  input  WIDTH  operand A, latched on accept
B  input  WIDTH  operand B, latched on accept
Ready  output  1  high in IDLE
Done  output  1  one-cycle pulse; Result/Zero/Overflow valid
Result  output  WIDTH  result register, held until next accept
Zero  output  1  Result == 0
Overflow  output  1  signed overflow (ADD/SUB only, else 0)
SliceA  output  1  latched A[idx]
SliceB  output  1  latched B[idx]
SliceAInvert  output  1  slice AInvert
SliceBInvert  output  1  slice BInvert
SliceCarryIn  output  1  carry register (pass start value for idx 0)
SliceLess  output  1  slice LESS input
SliceOperation  output  3  000 AND, 001 OR, 010 ADD, 011 LESS, 100 XOR
SliceResult  input  1  slice Result
SliceCarryOut  input  1  slice CarryOut

Behaviour:
- Reset values: state=IDLE, Ready=1, Done=0, Result=0, Zero=1, Overflow=0, idx=0, carry=0, all Slice* outputs 0.
- FSM states: IDLE, RUN, LESSPASS, DONE.
- IDLE:
  - Start=1 latches A, B and ALUOp, and sets idx=0.
  - Initial carry: 1 for SUB/SLT, else 0.
  - Next state: RUN. Ready drops the next cycle.
- Decode (registered with the opcode):
  - AND: op 000.
  - OR: op 001.
  - ADD: op 010.
  - XOR: op 100.
  - SUB: op 010, BInvert=1.
  - SLT: op 010, BInvert=1 in RUN; op 011 in LESSPASS.
  - NOR: op 000, AInvert=1, BInvert=1.
- RUN:
  - Slice inputs are driven combinationally from idx.
  - Each edge: Result[idx] <= SliceResult, carry <= SliceCarryOut, idx++.
  - At idx=WIDTH-1, also capture:
    - ovf = carry ^ SliceCarryOut (carry into MSB vs carry out)
    - set = SliceResult ^ ovf
  - After the idx=WIDTH-1 edge: next state is LESSPASS for SLT, else DONE. Overflow = ovf for ADD/SUB, else 0.
- LESSPASS (SLT only):
  - idx restarts at 0.
  - SliceLess = set at idx 0, else 0. AInvert=BInvert=CarryIn=0.
  - Collect SliceResult into Result over WIDTH cycles.
  - Then go to DONE. Overflow=0.
- DONE: Done=1 for exactly one cycle, Zero = (Result==0), then IDLE.
- Latency from the accept edge to the Done cycle:
  - WIDTH+1 cycles (25) for non-SLT ops.
  - 2*WIDTH+1 cycles (49) for SLT.
- Start while not Ready: ignored. No queueing, no effect on the in-flight operation.
- Start in the Done cycle: ignored; the request is accepted in the following IDLE cycle.
- Undefined ALUOp: no slice pass. Go directly to DONE next cycle with Result=0, Zero=1, Overflow=0.
- Reset mid-operation: aborts immediately to reset values. No Done pulse.
- Slice* outputs are 0 in IDLE and DONE.

Optional Feature:
Macro ALU_SEQ_SLTU_EN.
- Defined: adds ALUOp 1111 = SLTU.
  - Sequenced exactly like SLT.
  - set = ~final carry out (borrow), not sign ^ ovf.
  - Latency 49 cycles.
- Undefined: 1111 is treated as an undefined opcode (Result=0, Done after 1 cycle).

Test Plan:
- ADD A=0x7FFFFF, B=0x000001 -> Done 25 cycles after accept, Result=0x800000, Overflow=1, Zero=0.
- SUB A=0x000005, B=0x000005 -> Result=0x000000, Zero=1, Overflow=0. SliceCarryIn=1 on first RUN cycle.
- SLT A=0xFFFFFF (-1), B=0x000001 -> Done at 49 cycles, Result=0x000001. Swapped operands -> Result=0x000000.
- NOR A=0x0F0F0F, B=0x00FF00 -> Result=0xF000F0. XOR same operands -> 0x0FF00F.
- Start pulsed at cycles 3 and 10 after accept -> both ignored, single Done, Ready low throughout.
- Reset asserted at RUN idx=12 -> next cycle Ready=1, Result=0, no Done. Fresh ADD 1+2 then yields 0x000003.
